instruction_fetch_unit: RTL and testbench

IF-stage producer that feeds the IF/ID pipeline register. It owns the program counter and drives the program-ROM word address. It presents the fetched instruction and PC+4 to the IF/ID register's `pc_i`/`instr_i` inputs. It honours the same stall signal that freezes IF/ID and applies branch/jump redirects from ID, inserting one NOP bubble after every redirect.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_if.sv | 40 ++++
 rtl/instruction_fetch_unit_pc_register.sv | 34 +++
 rtl/instruction_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the instruction fetch stage.
//   RESET_PC  : PC after reset; program ROM word 0 lives here.
//   NOP_INSTR : instruction presented while the stage emits a bubble.
//   PC_INC    : sequential PC step (one 32-bit word).
//   fetch_state_e : BOOT / RUN / BUBBLE fetch sequencer states.
//   align_word()  : clears the two byte-offset bits of an address.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: groups the fetch stage's pipeline-control,
// program-ROM and IF/ID-facing signals.
//   master : the fetch unit (drives ROM address and IF/ID data)
//   slave  : the surroundings (ID redirect, hazard stall, ROM, IF/ID)
// Signals:
//   stall_i        1   hold PC/state (same as IF/ID reg_enabler)
//   redirect_i     1   taken branch / jump pulse from ID
//   redirect_pc_i  32  redirect target
//   rom_addr_o     AW  ROM word address
//   rom_data_i     32  combinational ROM read data
//   pc_o           32  PC+4 of instr_o
//   instr_o        32  fetched instruction or NOP
//   valid_o        1   instr_o is a real fetch
//   misalign_o     1   sticky misaligned-redirect flag
interface instruction_fetch_unit_if #(
  parameter int MEMORY_DEPTH = 32
);
  localparam int AW = $clog2(MEMORY_DEPTH);

  logic          stall_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic [AW-1:0] rom_addr_o;
  logic [31:0]   rom_data_i;
  logic [31:0]   pc_o;
  logic [31:0]   instr_o;
  logic          valid_o;
  logic          misalign_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, rom_data_i,
    output rom_addr_o, pc_o, instr_o, valid_o, misalign_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, rom_data_i,
    input  rom_addr_o, pc_o, instr_o, valid_o, misalign_o
  );

endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// pc_register: 32-bit program counter register.
//   clk     : rising-edge clock
//   reset   : synchronous active-low reset, loads RESET_VAL
//   en_i    : 1 = load d_i, 0 = hold
//   d_i     : next PC
//   q_o     : current PC
module pc_register
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] pc_q;

  // PC storage with synchronous reset and load enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_VAL;
    end else if (en_i) begin
      pc_q <= d_i;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage feeding the IF/ID pipeline register.
// Owns the PC, addresses the combinational program ROM and presents the
// fetched word plus PC+4 to IF/ID. Inserts one NOP bubble after reset and
// after every applied redirect; redirects seen under stall are parked and
// applied on the first unstalled cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-low reset
//   bus    : instruction_fetch_unit_if.master (stall, redirect, ROM, IF/ID)
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] RESET_PC     = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR    = mips_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  localparam int AW = $clog2(MEMORY_DEPTH);

  fetch_state_e state_q, state_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         pc_en_s;
  logic [31:0]  redirect_tgt_s;
  logic [31:0]  pc_off_s;

  assign redirect_tgt_s = align_word(bus.redirect_pc_i);

  pc_register #(
    .RESET_VAL (RESET_PC)
  ) u_pc_register (
    .clk   (clk),
    .reset (reset),
    .en_i  (pc_en_s),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  // State, pending-redirect and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= BOOT;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state, PC update and redirect capture/apply.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    misalign_d = misalign_q;
    pc_en_s    = 1'b0;
    pc_d       = pc_q;

    // Misalignment is flagged on every sampled redirect, stalled or not.
    if (bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end else begin
      misalign_d = misalign_q;
    end

    if (bus.stall_i) begin
      // Frozen: only park the newest redirect for later.
      if (bus.redirect_i) begin
        pend_d    = 1'b1;
        pend_pc_d = redirect_tgt_s;
      end else begin
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
      end
    end else if (bus.redirect_i || pend_q) begin
      // A live redirect supersedes a parked one, so the parked one is dropped.
      pc_en_s = 1'b1;
      pc_d    = bus.redirect_i ? redirect_tgt_s : pend_pc_q;
      pend_d  = 1'b0;
      state_d = BUBBLE;
    end else begin
      // BOOT and BUBBLE keep pc so the word at pc is fetched in the next RUN.
      case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        RUN: begin
          pc_en_s = 1'b1;
          pc_d    = pc_q + PC_INC;
          state_d = RUN;
        end
        BUBBLE: begin
          state_d = RUN;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // Word offset from the ROM base; wraps modulo MEMORY_DEPTH by truncation.
  assign pc_off_s       = pc_q - RESET_PC;
  assign bus.rom_addr_o = pc_off_s[AW+1:2];

  assign bus.valid_o    = (state_q == RUN);
  assign bus.pc_o       = pc_q + PC_INC;
  assign bus.instr_o    = bus.valid_o ? bus.rom_data_i : NOP_INSTR;
  assign bus.misalign_o = misalign_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.MEMORY_DEPTH(32)) bus();

  instruction_fetch_unit #(
    .MEMORY_DEPTH (32),
    .RESET_PC     (RPC),
    .NOP_INSTR    (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] rom [0:31];
  assign bus.rom_data_i = rom[bus.rom_addr_o];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic        emis;
  } vec_t;

  vec_t vt [18];

  // reference model state: "bubble" covers both boot and post-redirect cycles
  logic [31:0] mpc, mpend_pc, moff, eins;
  logic        mbub, mpend, mmis, st, rd, ev;
  logic [31:0] rpcv;
  int          eaddr;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s act=%h exp=%h", tag, fld, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] p);
    bus.stall_i       = s;
    bus.redirect_i    = r;
    bus.redirect_pc_i = p;
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pco, input logic mis);
    chk(tag, "valid", 32'(bus.valid_o), 32'(v));
    chk(tag, "instr", bus.instr_o, ins);
    chk(tag, "pc", bus.pc_o, pco);
    chk(tag, "misalign", 32'(bus.misalign_o), 32'(mis));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    adv();
    adv();
    expect_out("reset", 1'b0, 32'h0, RPC + 32'd4, 1'b0);
    chk("reset", "addr", 32'(bus.rom_addr_o), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'(i + 1);
    reset = 1'b0;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;

    //           stall redir rpc           valid instr  pc_o           mis
    vt[0]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'd0, 32'h0040_0004, 1'b0}; // boot bubble
    vt[1]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'd1, 32'h0040_0004, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'd2, 32'h0040_0008, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'd3, 32'h0040_000C, 1'b0}; // stall x3
    vt[4]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'd3, 32'h0040_000C, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 32'h0,          1'b1, 32'd3, 32'h0040_000C, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 32'h0,          1'b1, 32'd3, 32'h0040_000C, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'h0040_0010,  1'b1, 32'd4, 32'h0040_0010, 1'b0}; // redirect
    vt[8]  = '{1'b0, 1'b0, 32'h0,          1'b0, 32'd0, 32'h0040_0014, 1'b0}; // bubble
    vt[9]  = '{1'b1, 1'b1, 32'h0040_0020,  1'b1, 32'd5, 32'h0040_0014, 1'b0}; // redirect under stall
    vt[10] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'd5, 32'h0040_0014, 1'b0};
    vt[11] = '{1'b1, 1'b0, 32'h0,          1'b1, 32'd5, 32'h0040_0014, 1'b0};
    vt[12] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'd5, 32'h0040_0014, 1'b0}; // release, pend applies
    vt[13] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'd0, 32'h0040_0024, 1'b0};
    vt[14] = '{1'b0, 1'b1, 32'h0040_0013,  1'b1, 32'd9, 32'h0040_0024, 1'b0}; // misaligned target
    vt[15] = '{1'b0, 1'b0, 32'h0,          1'b0, 32'd0, 32'h0040_0014, 1'b1};
    vt[16] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'd5, 32'h0040_0014, 1'b1};
    vt[17] = '{1'b0, 1'b0, 32'h0,          1'b1, 32'd6, 32'h0040_0018, 1'b1};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].stall, vt[i].redir, vt[i].rpc);
      expect_out($sformatf("vec%0d", i), vt[i].ev, vt[i].einstr, vt[i].epc, vt[i].emis);
      adv();
    end

    // redirect arriving in the bubble cycle restarts the sequence
    drive(1'b0, 1'b1, 32'h0040_0040);
    expect_out("rb0", 1'b1, 32'd7, 32'h0040_001C, 1'b1);
    adv();
    drive(1'b0, 1'b1, 32'h0040_0008);
    expect_out("rb1", 1'b0, 32'd0, 32'h0040_0044, 1'b1);
    adv();
    drive(1'b0, 1'b0, 32'h0);
    expect_out("rb2", 1'b0, 32'd0, 32'h0040_000C, 1'b1);
    adv();
    expect_out("rb3", 1'b1, 32'd3, 32'h0040_000C, 1'b1);

    // ROM address wraps 31 -> 0 while pc keeps counting
    drive(1'b0, 1'b1, 32'h0040_007C);
    adv();
    drive(1'b0, 1'b0, 32'h0);
    adv();
    expect_out("wr0", 1'b1, 32'd32, 32'h0040_0080, 1'b1);
    chk("wr0", "addr", 32'(bus.rom_addr_o), 32'd31);
    adv();
    expect_out("wr1", 1'b1, 32'd1, 32'h0040_0084, 1'b1);
    chk("wr1", "addr", 32'(bus.rom_addr_o), 32'd0);

    // 32-bit PC wrap
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    adv();
    drive(1'b0, 1'b0, 32'h0);
    chk("pw0", "pc", bus.pc_o, 32'h0000_0000);
    adv();
    chk("pw1", "pc", bus.pc_o, 32'h0000_0000);
    chk("pw1", "addr", 32'(bus.rom_addr_o), 32'd31);
    adv();
    chk("pw2", "pc", bus.pc_o, 32'h0000_0004);
    chk("pw2", "addr", 32'(bus.rom_addr_o), 32'd0);

    // reset while a redirect is parked: pend and misalign discarded
    drive(1'b1, 1'b1, 32'h0040_0040);
    adv();
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    adv();
    expect_out("rp0", 1'b0, 32'd0, 32'h0040_0004, 1'b0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    expect_out("rp1", 1'b0, 32'd0, 32'h0040_0004, 1'b0);
    adv();
    expect_out("rp2", 1'b1, 32'd1, 32'h0040_0004, 1'b0);
    adv();
    expect_out("rp3", 1'b1, 32'd2, 32'h0040_0008, 1'b0);

    // randomized run against the reference model
    do_reset();
    mpc = RPC; mbub = 1'b1; mpend = 1'b0; mpend_pc = 32'h0; mmis = 1'b0;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 3) == 0) rpcv = $urandom;
      else rpcv = RPC + 32'($urandom_range(0, 63) * 4)
                  + (($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
      drive(st, rd, rpcv);

      moff  = mpc - RPC;
      eaddr = int'((moff / 32'd4) % 32'd32);
      ev    = !mbub;
      eins  = ev ? rom[eaddr] : 32'h0;
      expect_out("rnd", ev, eins, mpc + 32'd4, mmis);
      chk("rnd", "addr", 32'(bus.rom_addr_o), 32'(eaddr));

      if (rd && (rpcv % 32'd4 != 32'd0)) mmis = 1'b1;
      if (st) begin
        if (rd) begin
          mpend = 1'b1;
          mpend_pc = rpcv - (rpcv % 32'd4);
        end
      end else if (rd || mpend) begin
        mpc   = rd ? (rpcv - (rpcv % 32'd4)) : mpend_pc;
        mpend = 1'b0;
        mbub  = 1'b1;
      end else begin
        if (!mbub) mpc = mpc + 32'd4;
        mbub = 1'b0;
      end
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
